// File: rtl/ahbl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahbl_pkg : shared AHB-Lite encodings and subordinate FSM states   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package ahbl_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   localparam logic c_HRESP_OKAY  = 1'b0;
   localparam logic c_HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slv_state_e;

endpackage
`default_nettype wire

// File: rtl/ahbl_wstrb_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahbl_wstrb_gen : hsize/addr[1:0] to byte strobe + misalign flag   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module ahbl_wstrb_gen
   import ahbl_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr,
   output logic [3:0] strb,
   output logic       misalign
);

   // Sizes above a word produce no strobe; the caller flags them as errors.
   always_comb begin
      strb     = 4'b0000;
      misalign = 1'b0;
      case (hsize)
         HSIZE_BYTE: strb = 4'b0001 << addr;
         HSIZE_HALF: begin
            strb     = addr[1] ? 4'b1100 : 4'b0011;
            misalign = addr[0];
         end
         HSIZE_WORD: begin
            strb     = 4'b1111;
            misalign = |addr;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ahbl_mem_slv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahbl_mem_slv : AHB-Lite memory subordinate with wait/ERROR resp   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module ahbl_mem_slv
   import ahbl_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)
(
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic        hwrite,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   localparam int          c_AW    = $clog2(DEPTH);
   localparam logic [31:0] c_BYTES = 32'(DEPTH * 4);
   localparam logic [3:0]  c_WS    = 4'(WAIT_STATES);

   slv_state_e        r_state, w_state_nxt;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic [c_AW-1:0]   r_idx;
   logic [3:0]        r_strb;
   logic              r_write;
   logic [31:0]       r_mem [DEPTH];

   logic [31:0]       w_off;
   logic [3:0]        w_strb;
   logic              w_misalign;
   logic              w_accept;
   logic              w_err;
   logic              w_take;
   logic              w_unused;

   assign w_off    = haddr - BASE_ADDR;
   assign w_accept = hsel & hready & htrans[1];
   assign w_err    = (w_off >= c_BYTES) | (hsize > HSIZE_WORD) | w_misalign;
   assign w_unused = ^{hburst, hprot, w_off[31:c_AW+2], w_off[1:0]};

   ahbl_wstrb_gen u_wstrb (
      .hsize    (hsize),
      .addr     (haddr[1:0]),
      .strb     (w_strb),
      .misalign (w_misalign)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      hreadyout   = 1'b1;
      hresp       = c_HRESP_OKAY;
      case (r_state)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (r_state == ST_ERR2) hresp = c_HRESP_ERROR;
            w_take = w_accept;
            if (!w_accept) begin
               w_state_nxt = ST_IDLE;
            end else if (w_err) begin
               w_state_nxt = ST_ERR1;
            end else if (c_WS != 4'd0) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = c_WS;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_WAIT: begin
            hreadyout = 1'b0;
            if (r_cnt <= 4'd1) begin
               w_state_nxt = ST_DATA;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_ERR1: begin
            hreadyout   = 1'b0;
            hresp       = c_HRESP_ERROR;
            w_state_nxt = ST_ERR2;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_strb  <= 4'b0000;
         r_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_take) begin
            r_idx   <= w_off[c_AW+1:2];
            r_strb  <= w_strb;
            r_write <= hwrite;
         end
      end
   end

   // Commit happens on the edge that closes DATA, so a read accepted on
   // that same edge sees the new word in its own data phase.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_state == ST_DATA && r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

   assign hrdata = (r_state == ST_DATA) ? r_mem[r_idx] : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_mem_slv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ahbl_mem_slv : scoreboard bench, WAIT_STATES=0 and =1 targets  |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ahbl_mem_slv;

   typedef struct {
      string       tag;
      bit          wr;
      bit          err;
      logic [31:0] rd;
      int          stall;
   } exp_t;

   localparam int c_WS0 = 0;
   localparam int c_WS1 = 1;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        sel   [2];
   logic [31:0] addr  [2];
   logic [1:0]  trans [2];
   logic [2:0]  size  [2];
   logic        write [2];
   logic [31:0] wdata [2];
   logic        rdy   [2];
   logic        resp  [2];
   logic [31:0] rdata [2];
   logic [2:0]  burst = 3'b000;
   logic [3:0]  prot  = 4'b0011;

   exp_t q0[$];
   exp_t q1[$];
   int   stall [2];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 hclk = ~hclk;

   ahbl_mem_slv #(.DEPTH(256), .WAIT_STATES(c_WS0), .BASE_ADDR(32'h0)) u_dut_ws0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(sel[0]), .haddr(addr[0]),
      .htrans(trans[0]), .hsize(size[0]), .hburst(burst), .hprot(prot),
      .hwrite(write[0]), .hwdata(wdata[0]), .hready(rdy[0]),
      .hreadyout(rdy[0]), .hresp(resp[0]), .hrdata(rdata[0])
   );

   ahbl_mem_slv #(.DEPTH(256), .WAIT_STATES(c_WS1), .BASE_ADDR(32'h0)) u_dut_ws1 (
      .hclk(hclk), .hresetn(hresetn), .hsel(sel[1]), .haddr(addr[1]),
      .htrans(trans[1]), .hsize(size[1]), .hburst(burst), .hprot(prot),
      .hwrite(write[1]), .hwdata(wdata[1]), .hready(rdy[1]),
      .hreadyout(rdy[1]), .hresp(resp[1]), .hrdata(rdata[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Data-phase checker: counts stall cycles, then checks response/data on the ready cycle.
   task automatic mon(input int d);
      exp_t e;
      if (d == 0) begin
         if (q0.size() == 0) return;
         e = q0[0];
      end else begin
         if (q1.size() == 0) return;
         e = q1[0];
      end
      if (rdy[d] !== 1'b1 && stall[d] < 20) begin
         stall[d]++;
         chk({e.tag, "_stall_resp"}, {31'd0, resp[d]}, {31'd0, e.err});
         chk({e.tag, "_stall_rdata"}, rdata[d], 32'h0);
      end else begin
         chk({e.tag, "_stalls"}, stall[d], e.stall);
         chk({e.tag, "_resp"}, {31'd0, resp[d]}, {31'd0, e.err});
         if (!e.wr || e.err) chk({e.tag, "_rdata"}, rdata[d], e.rd);
         stall[d] = 0;
         if (d == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
      end
   endtask

   always @(negedge hclk) begin
      mon(0);
      mon(1);
   end

   // Holds the address phase until accepted, then drives write data and records the expectation.
   task automatic issue(input int d, input string tag, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input bit err,
                        input logic [31:0] rd);
      exp_t e;
      bit   ok;
      sel[d]   = 1'b1;
      trans[d] = 2'b10;
      addr[d]  = a;
      write[d] = wr;
      size[d]  = sz;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge hclk);
         ok = (rdy[d] === 1'b1);
         @(posedge hclk);
      end
      #1;
      sel[d]   = 1'b0;
      trans[d] = 2'b00;
      wdata[d] = wd;
      if (!ok) begin
         n_vec++;
         n_err++;
         $error("FAIL %s_accept: observed no-accept expected accept", tag);
         return;
      end
      e.tag   = tag;
      e.wr    = wr;
      e.err   = err;
      e.rd    = rd;
      e.stall = err ? 1 : (d == 0 ? c_WS0 : c_WS1);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic drain(input int d);
      int left;
      left = 1;
      for (int n = 0; n < 40 && left != 0; n++) begin
         left = (d == 0) ? q0.size() : q1.size();
         if (left != 0) @(negedge hclk);
      end
      if (left != 0) begin
         n_vec++;
         n_err++;
         $error("FAIL drain%0d: observed %0d pending expected 0", d, left);
      end
      @(posedge hclk);
      #1;
   endtask

   initial begin
      hresetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sel[d] = 1'b0; addr[d] = '0; trans[d] = 2'b00;
         size[d] = 3'd2; write[d] = 1'b0; wdata[d] = '0; stall[d] = 0;
      end
      repeat (3) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(posedge hclk);
      #1;
      chk("rst_hreadyout", {31'd0, rdy[1]}, 32'd1);
      chk("rst_hresp", {31'd0, resp[1]}, 32'd0);
      chk("rst_hrdata", rdata[1], 32'h0);

      issue(1, "rd0_after_rst", 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 32'h0000_0000);

      issue(1, "wr_10", 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0);
      issue(1, "rd_10", 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);

      issue(1, "wr_20_w", 1'b1, 32'h20, 3'd2, 32'h0000_0000, 1'b0, 32'h0);
      issue(1, "wr_21_b", 1'b1, 32'h21, 3'd0, 32'h0000_AA00, 1'b0, 32'h0);
      issue(1, "wr_22_h", 1'b1, 32'h22, 3'd1, 32'h1234_0000, 1'b0, 32'h0);
      issue(1, "rd_20", 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h1234_AA00);
      drain(1);

      issue(0, "ws0_wr_40", 1'b1, 32'h40, 3'd2, 32'h5555_5555, 1'b0, 32'h0);
      issue(0, "ws0_rd_40", 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'h5555_5555);
      issue(0, "ws0_wr_44_b", 1'b1, 32'h47, 3'd0, 32'h7700_0000, 1'b0, 32'h0);
      issue(0, "ws0_rd_44", 1'b0, 32'h44, 3'd2, 32'h0, 1'b0, 32'h7700_0000);
      drain(0);

      issue(1, "err_rd_400", 1'b0, 32'h400, 3'd2, 32'h0, 1'b1, 32'h0);
      issue(1, "err_wr_02", 1'b1, 32'h2, 3'd2, 32'hFFFF_FFFF, 1'b1, 32'h0);
      issue(1, "ok_after_err", 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
      issue(1, "err_half_odd", 1'b1, 32'h21, 3'd1, 32'hFFFF_FFFF, 1'b1, 32'h0);
      issue(1, "err_size3", 1'b0, 32'h30, 3'd3, 32'h0, 1'b1, 32'h0);
      issue(1, "rd_0_unchanged", 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 32'h0000_0000);
      issue(1, "rd_20_unchanged", 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h1234_AA00);
      issue(1, "rd_top_word", 1'b0, 32'h3FC, 3'd2, 32'h0, 1'b0, 32'h0000_0000);
      drain(1);

      // Write to 0x8 aborted by reset while its data phase is stalled.
      sel[1] = 1'b1; trans[1] = 2'b10; addr[1] = 32'h8; write[1] = 1'b1; size[1] = 3'd2;
      @(posedge hclk);
      #1;
      sel[1] = 1'b0; trans[1] = 2'b00; wdata[1] = 32'hFFFF_FFFF;
      chk("midrst_in_wait", {31'd0, rdy[1]}, 32'd0);
      hresetn = 1'b0;
      #1;
      chk("midrst_hreadyout", {31'd0, rdy[1]}, 32'd1);
      chk("midrst_hresp", {31'd0, resp[1]}, 32'd0);
      chk("midrst_hrdata", rdata[1], 32'h0);
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(posedge hclk);
      #1;
      issue(1, "rd_8_after_rst", 1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 32'h0000_0000);
      issue(1, "rd_10_after_rst", 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'h0000_0000);
      drain(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
